// File: rtl/pipe_addsub_if.sv
// pipe_addsub_if -- handshake and data bundle for the pipelined adder/subtractor.
//   master : operand source and result sink (drives in_valid, a, b, c_in, sub, out_ready)
//   slave  : the adder itself (drives in_ready, out_valid, s, c_out, ovf)
interface pipe_addsub_if #(
    parameter int SIZE = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            c_in;
    logic            sub;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] s;
    logic            c_out;
    logic            ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf
    );
endinterface

// File: rtl/pipe_addsub.sv
// pipe_addsub -- SIZE-bit adder/subtractor whose ripple chain is cut into STAGES
// registered chunks of W = SIZE/STAGES bits. One operand pair per cycle under
// valid/ready; result, carry-out and signed overflow appear STAGES edges after
// acceptance (counting the acceptance edge).
//   clk, rst_n : clock, asynchronous active-low reset
//   io (slave) : in_valid/in_ready/a/b/c_in/sub in, out_valid/out_ready/s/c_out/ovf out

// Full-adder cell used for every bit of the chain.
module pipe_addsub_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module pipe_addsub #(
    parameter int SIZE   = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_addsub_if.slave io
);
    localparam int W = SIZE / STAGES;

    logic            adv;
    logic [SIZE-1:0] b_eff;
    logic            cin_eff;

    // One advance signal for the whole pipe: it moves whenever the output
    // register is empty or being drained. Bubbles travel like data.
    assign adv         = io.out_ready || !io.out_valid;
    assign io.in_ready = adv;

    // Subtraction is folded in at entry, so sub/c_in need not travel further.
    assign b_eff   = io.sub ? ~io.b : io.b;
    assign cin_eff = io.sub ? 1'b1 : io.c_in;

    // Stage k adds chunk k. Bits above the chunk are carried forward as the
    // skew registers; the low sums accumulated so far are carried forward as
    // the deskew registers, so stage k's sum register holds bits [HI-1:0].
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * W;
        localparam int HI = LO + W;

        logic [SIZE-1:LO] opa_w;
        logic [SIZE-1:LO] opb_w;
        logic             cin_w;
        logic             vld_w;
        logic [W:0]       cc;
        logic [W-1:0]     chunk_s;
        logic [HI-1:0]    sum_d;
        logic [HI-1:0]    sum_q;
        logic             carry_q;
        logic             vld_q;

        if (k == 0) begin : g_src
            assign opa_w = io.a;
            assign opb_w = b_eff;
            assign cin_w = cin_eff;
            assign vld_w = io.in_valid;
            assign sum_d = chunk_s;
        end else begin : g_src
            assign opa_w = g_st[k-1].g_fwd.opa_q;
            assign opb_w = g_st[k-1].g_fwd.opb_q;
            assign cin_w = g_st[k-1].carry_q;
            assign vld_w = g_st[k-1].vld_q;
            assign sum_d = {chunk_s, g_st[k-1].sum_q};
        end

        assign cc[0] = cin_w;
        for (genvar i = 0; i < W; i++) begin : g_fa
            pipe_addsub_fa u_fa (
                .a_i (opa_w[LO+i]),
                .b_i (opb_w[LO+i]),
                .c_i (cc[i]),
                .s_o (chunk_s[i]),
                .c_o (cc[i+1])
            );
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
                vld_q   <= 1'b0;
            end else if (adv) begin
                sum_q   <= sum_d;
                carry_q <= cc[W];
                vld_q   <= vld_w;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [SIZE-1:HI] opa_q;
            logic [SIZE-1:HI] opb_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (adv) begin
                    opa_q <= opa_w[SIZE-1:HI];
                    opb_q <= opb_w[SIZE-1:HI];
                end
            end
        end

        if (k == STAGES - 1) begin : g_msb
            // Carry into the MSB; XOR with the final carry gives signed overflow.
            logic cmsb_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cmsb_q <= 1'b0;
                end else if (adv) begin
                    cmsb_q <= cc[W-1];
                end
            end
        end
    end

    assign io.out_valid = g_st[STAGES-1].vld_q;
    assign io.s         = g_st[STAGES-1].sum_q;
    assign io.c_out     = g_st[STAGES-1].carry_q;
    assign io.ovf       = g_st[STAGES-1].carry_q ^ g_st[STAGES-1].g_msb.cmsb_q;
endmodule
